// File: rtl/apb_mem_slave.sv
// APB3 completer with a DEPTH x 32-bit word-addressed register memory and PSLVERR decode.
// Optional wait-state insertion is built only when APB_SLV_WAIT_EN is defined.
module apb_mem_slave #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Misaligned byte address or word index beyond the memory.
    function automatic logic decode_err(input logic [31:0] addr);
        decode_err = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        write_r;
    logic [31:0] prdata_r;
    logic        pready_r;
    logic        pslverr_r;
    logic [31:0] mem_r [DEPTH];

    logic        capture_s;
    logic        respond_s;
    logic        clear_s;
    logic        commit_s;
    logic [31:0] resp_addr_s;
    logic        resp_write_s;
    logic        resp_err_s;
    logic [31:0] prdata_s;
    logic        pready_s;
    logic        pslverr_s;

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
`endif

    // Next-state, capture, response-timing and commit decisions.
    always_comb begin
        state_s      = state_r;
        capture_s    = 1'b0;
        respond_s    = 1'b0;
        clear_s      = 1'b0;
        commit_s     = 1'b0;
        resp_addr_s  = addr_r;
        resp_write_s = write_r;
`ifdef APB_SLV_WAIT_EN
        cnt_s        = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                // A transfer starting without SETUP (penable already high) is ignored.
                if (psel && !penable) begin
                    state_s      = ACCESS;
                    capture_s    = 1'b1;
                    resp_addr_s  = paddr;
                    resp_write_s = pwrite;
`ifdef APB_SLV_WAIT_EN
                    cnt_s        = WAIT_LOAD;
                    respond_s    = (WAIT_LOAD == 4'd0);
`else
                    respond_s    = 1'b1;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_s = IDLE;
                    clear_s = 1'b1;
`ifdef APB_SLV_WAIT_EN
                    cnt_s   = 4'd0;
`endif
                end else if (penable && pready_r) begin
                    state_s  = IDLE;
                    clear_s  = 1'b1;
                    commit_s = write_r && !pslverr_r;
`ifdef APB_SLV_WAIT_EN
                end else if (penable && (cnt_r != 4'd0)) begin
                    cnt_s     = cnt_r - 4'd1;
                    respond_s = (cnt_r == 4'd1);
`endif
                end else begin
                    state_s = ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
                clear_s = 1'b1;
            end
        endcase
    end

    // Registered response values: load on response, zero on completion/abort, else hold.
    always_comb begin
        resp_err_s = decode_err(resp_addr_s);
        prdata_s   = prdata_r;
        pready_s   = pready_r;
        pslverr_s  = pslverr_r;
        if (respond_s) begin
            pready_s  = 1'b1;
            pslverr_s = resp_err_s;
            if (resp_write_s || resp_err_s) begin
                prdata_s = 32'h0000_0000;
            end else begin
                prdata_s = mem_r[resp_addr_s[IDX_W+1:2]];
            end
        end else if (clear_s) begin
            prdata_s  = 32'h0000_0000;
            pready_s  = 1'b0;
            pslverr_s = 1'b0;
        end else begin
            prdata_s  = prdata_r;
        end
    end

    // State, capture registers, outputs and memory; reset wins over any in-flight write.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r   <= IDLE;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            write_r   <= 1'b0;
            prdata_r  <= 32'h0000_0000;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt_r     <= 4'd0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            state_r   <= state_s;
            prdata_r  <= prdata_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
`ifdef APB_SLV_WAIT_EN
            cnt_r     <= cnt_s;
`endif
            if (capture_s) begin
                addr_r  <= paddr;
                wdata_r <= pwdata;
                write_r <= pwrite;
            end
            if (commit_s) begin
                mem_r[addr_r[IDX_W+1:2]] <= wdata_r;
            end
        end
    end

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed self-checking bench for apb_mem_slave; drives after posedge, samples on negedge.
module tb_apb_mem_slave;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif
    localparam int EXP_LEN = EXP_WAIT + 2;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          cyc2;

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(2)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    // One full transfer; optionally disturbs paddr/pwdata after the SETUP edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input bit scramble, output logic [31:0] rdata, output logic err,
                            output int cycles);
        bit done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        cycles = 1;
        penable = 1'b1;
        if (scramble) begin
            paddr  = addr ^ 32'h0000_000C;
            pwdata = ~data;
        end
        done = 1'b0; rdata = 32'h0; err = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                done = 1'b1; rdata = prdata; err = pslverr;
            end
            @(posedge pclk); #1;
            cycles++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL xfer_timeout addr=%h: pready never seen, required within 20 cycles", addr);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got=%b exp=0", pready); end
        n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    endtask

    task automatic test_read_after_reset();
        apb_xfer(1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd0c_data got=%h exp=0", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd0c_err got=%b exp=0", er); end
        n_checks++; if (cyc !== EXP_LEN) begin n_fail++; $display("FAIL rd0c_len got=%0d exp=%0d", cyc, EXP_LEN); end
        @(negedge pclk);
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL pready_pulse got=%b exp=0", pready); end
    endtask

    task automatic test_write_read();
        apb_xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr08_err got=%b exp=0", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr08_prdata got=%h exp=0", rd); end
        apb_xfer(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, er, cyc2);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd08_data got=%h exp=deadbeef", rd); end
        n_checks++; if ((cyc + cyc2) !== 2 * EXP_LEN) begin n_fail++; $display("FAIL wr_rd_pair_len got=%0d exp=%0d", cyc + cyc2, 2 * EXP_LEN); end
    endtask

    task automatic test_capture();
        apb_xfer(1'b1, 32'h0000_0004, 32'h1111_1111, 1'b1, rd, er, cyc);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL cap_err got=%b exp=0", er); end
        apb_xfer(1'b0, 32'h0000_0004, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL cap_rd04 got=%h exp=11111111", rd); end
        apb_xfer(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cap_rd08 got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_errors();
        apb_xfer(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr00_err got=%b exp=0", er); end
        apb_xfer(1'b1, 32'h0000_0040, 32'hBAD0_BAD0, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL wr40_err got=%b exp=1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr40_prdata got=%h exp=0", rd); end
        apb_xfer(1'b0, 32'h0000_0000, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL oor_mem_intact got=%h exp=a5a5a5a5", rd); end
        apb_xfer(1'b0, 32'h0000_0006, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL rd06_err got=%b exp=1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd06_data got=%h exp=0", rd); end
        apb_xfer(1'b1, 32'h0000_0005, 32'hCAFE_F00D, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL wr05_err got=%b exp=1", er); end
        apb_xfer(1'b0, 32'h0000_0004, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL mis_mem_intact got=%h exp=11111111", rd); end
        apb_xfer(1'b0, 32'h0000_003C, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd3c_err got=%b exp=0", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd3c_data got=%h exp=0", rd); end
    endtask

    task automatic test_abort();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_000C; pwdata = 32'h7777_7777;
        @(posedge pclk); #1;
        psel = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL abort_pready got=%b exp=0", pready); end
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL abort_prdata got=%h exp=0", prdata); end
        apb_xfer(1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_no_commit got=%h exp=0", rd); end
    endtask

    task automatic test_protocol_violation();
        bit seen;
        seen = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0000_000C; pwdata = 32'h9999_9999;
        repeat (4) begin
            @(negedge pclk);
            if (pready !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL noseq_pready got=1 exp=0"); end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noseq_no_write got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        @(posedge pclk); #1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h1000_0000 + 32'(i);
            apb_xfer(1'b1, 32'(i * 4), exp_d, 1'b0, rd, er, cyc);
            n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_err[%0d] got=%b exp=0", i, er); end
            n_checks++; if (cyc !== EXP_LEN) begin n_fail++; $display("FAIL b2b_wr_len[%0d] got=%0d exp=%0d", i, cyc, EXP_LEN); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h1000_0000 + 32'(i);
            apb_xfer(1'b0, 32'(i * 4), 32'h0, 1'b0, rd, er, cyc);
            n_checks++; if (rd !== exp_d) begin n_fail++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, rd, exp_d); end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0010; pwdata = 32'h55AA_55AA;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pready got=%b exp=0", pready); end
        n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL rstmid_pslverr got=%b exp=0", pslverr); end
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_prdata got=%h exp=0", prdata); end
        apb_xfer(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_commit got=%h exp=0", rd); end
        apb_xfer(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem_clear got=%h exp=0", rd); end
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_capture();
        test_errors();
        test_abort();
        test_protocol_violation();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
